// File: rtl/abc_to_dq.sv
// abc_to_dq: sequential forward Clarke + Park transform.
// Converts phase quantities A/B/C into rotor-frame d/q using CosQ/SinQ.
// All words are 24-bit sign-magnitude Q12 (bit 23 sign, bits 22:0 magnitude).
// One shared multiplier and one shared adder are stepped through twelve
// operations by a small FSM; results appear together with a one-cycle valid.
module abc_to_dq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] A,
    input  logic [23:0] B,
    input  logic [23:0] C,
    input  logic [23:0] CosQ,
    input  logic [23:0] SinQ,
    output logic [23:0] d,
    output logic [23:0] q,
    output logic        valid,
    output logic        busy,
    output logic        ovf
);

    localparam int          N   = 24;
    localparam int          Q   = 12;
    localparam logic [N-1:0] K3  = 24'h000555;
    localparam logic [N-1:0] KS3 = 24'h00093D;
    localparam logic [N-2:0] MAG_MAX = 23'h7FFFFF;

    typedef enum logic [3:0] {
        IDLE, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12
    } state_t;

    state_t state, state_next;

    // Captured operands (isolated from the live inputs once accepted)
    logic [N-1:0] a_r, b_r, c_r, cos_r, sin_r;
    // Intermediate results
    logic [N-1:0] t, u, alpha, beta, p1, p2, p3, p4, d_acc;
    logic         ovf_flag;

    // Shared arithmetic operands and results
    logic [N-1:0]   mul_a, mul_b, mul_res;
    logic           mul_ovf;
    logic [2*N-3:0] mul_prod;
    logic [N-2:0]   mul_mag;

    logic [N-1:0] add_a, add_b, add_res;
    logic         add_ovf;
    logic [N-1:0] add_sum;
    logic [N-2:0] add_mag;
    logic         add_sign;

    logic step_ovf;
    logic accept;

    // Negative zero is folded to +0 so every stored word is canonical.
    function automatic logic [N-1:0] canon(input logic [N-1:0] x);
        return (x[N-2:0] == '0) ? '0 : x;
    endfunction

    // Flipping the sign turns the shared adder into a subtractor.
    function automatic logic [N-1:0] negate(input logic [N-1:0] x);
        return {~x[N-1], x[N-2:0]};
    endfunction

    // The final step doubles as an accepting slot so conversions can run back to back.
    assign accept = start && (state == IDLE || state == S12);
    assign busy   = (state != IDLE);

    // Shared multiplier: 23x23 magnitude product, Q12 truncation, saturation on overflow.
    always_comb begin
        mul_prod = {{(N-1){1'b0}}, mul_a[N-2:0]} * {{(N-1){1'b0}}, mul_b[N-2:0]};
        mul_ovf  = |mul_prod[2*N-3:Q+N-1];
        mul_mag  = mul_ovf ? MAG_MAX : mul_prod[Q+N-2:Q];
        mul_res  = (mul_mag == '0) ? '0 : {mul_a[N-1] ^ mul_b[N-1], mul_mag};
    end

    // Shared sign-magnitude adder with saturation on same-sign magnitude carry-out.
    always_comb begin
        add_sum  = {1'b0, add_a[N-2:0]} + {1'b0, add_b[N-2:0]};
        add_ovf  = 1'b0;
        add_sign = add_a[N-1];
        add_mag  = '0;
        if (add_a[N-1] == add_b[N-1]) begin
            if (add_sum[N-1]) begin
                add_mag = MAG_MAX;
                add_ovf = 1'b1;
            end else begin
                add_mag = add_sum[N-2:0];
            end
        end else if (add_a[N-2:0] >= add_b[N-2:0]) begin
            add_mag = add_a[N-2:0] - add_b[N-2:0];
        end else begin
            add_mag  = add_b[N-2:0] - add_a[N-2:0];
            add_sign = add_b[N-1];
        end
        add_res = (add_mag == '0) ? '0 : {add_sign, add_mag};
    end

    // Step sequencing: routes operands to the shared units and picks the next state.
    always_comb begin
        state_next = state;
        mul_a      = '0;
        mul_b      = '0;
        add_a      = '0;
        add_b      = '0;
        step_ovf   = 1'b0;
        case (state)
            IDLE: if (start) state_next = S1;
            S1:  begin add_a = a_r;   add_b = a_r;          step_ovf = add_ovf; state_next = S2;  end
            S2:  begin add_a = t;     add_b = negate(b_r);  step_ovf = add_ovf; state_next = S3;  end
            S3:  begin add_a = t;     add_b = negate(c_r);  step_ovf = add_ovf; state_next = S4;  end
            S4:  begin mul_a = t;     mul_b = K3;           step_ovf = mul_ovf; state_next = S5;  end
            S5:  begin add_a = b_r;   add_b = negate(c_r);  step_ovf = add_ovf; state_next = S6;  end
            S6:  begin mul_a = u;     mul_b = KS3;          step_ovf = mul_ovf; state_next = S7;  end
            S7:  begin mul_a = alpha; mul_b = cos_r;        step_ovf = mul_ovf; state_next = S8;  end
            S8:  begin mul_a = beta;  mul_b = sin_r;        step_ovf = mul_ovf; state_next = S9;  end
            S9:  begin add_a = p1;    add_b = p2;           step_ovf = add_ovf; state_next = S10; end
            S10: begin mul_a = beta;  mul_b = cos_r;        step_ovf = mul_ovf; state_next = S11; end
            S11: begin mul_a = alpha; mul_b = sin_r;        step_ovf = mul_ovf; state_next = S12; end
            S12: begin
                add_a      = p3;
                add_b      = negate(p4);
                step_ovf   = add_ovf;
                state_next = start ? S1 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture, intermediate results, sticky overflow and the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            cos_r    <= '0;
            sin_r    <= '0;
            t        <= '0;
            u        <= '0;
            alpha    <= '0;
            beta     <= '0;
            p1       <= '0;
            p2       <= '0;
            p3       <= '0;
            p4       <= '0;
            d_acc    <= '0;
            ovf_flag <= 1'b0;
            d        <= '0;
            q        <= '0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            valid <= (state == S12);
            ovf   <= (state == S12) && (ovf_flag || step_ovf);
            case (state)
                S1, S2, S3: t     <= add_res;
                S4:         alpha <= mul_res;
                S5:         u     <= add_res;
                S6:         beta  <= mul_res;
                S7:         p1    <= mul_res;
                S8:         p2    <= mul_res;
                S9:         d_acc <= add_res;
                S10:        p3    <= mul_res;
                S11:        p4    <= mul_res;
                S12: begin
                    d <= d_acc;
                    q <= add_res;
                end
                default: ;
            endcase
            if (accept) begin
                a_r      <= canon(A);
                b_r      <= canon(B);
                c_r      <= canon(C);
                cos_r    <= canon(CosQ);
                sin_r    <= canon(SinQ);
                ovf_flag <= 1'b0;
            end else if (state != IDLE) begin
                ovf_flag <= ovf_flag || step_ovf;
            end
        end
    end

endmodule

// File: tb/tb_abc_to_dq.sv
// Directed testbench for abc_to_dq with hand-computed Q12 expectations.
module tb_abc_to_dq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] A = '0, B = '0, C = '0, CosQ = '0, SinQ = '0;
    logic [23:0] d, q;
    logic        valid, busy, ovf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    abc_to_dq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .CosQ  (CosQ),
        .SinQ  (SinQ),
        .d     (d),
        .q     (q),
        .valid (valid),
        .busy  (busy),
        .ovf   (ovf)
    );

    // Launch one conversion, scramble the inputs after acceptance, wait for valid.
    task automatic run_conv(input logic [23:0] a, b, c, cs, sn,
                            output logic [23:0] od, oq, output logic oovf,
                            output int lat, output int busy_hi);
        int i;
        od = 'x; oq = 'x; oovf = 1'bx; lat = -1; busy_hi = 0; i = 0;
        @(negedge clk);
        A = a; B = b; C = c; CosQ = cs; SinQ = sn; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 24'($urandom); B = 24'($urandom); C = 24'($urandom);
        CosQ = 24'($urandom); SinQ = 24'($urandom);
        if (busy === 1'b1) busy_hi++;
        while (lat < 0 && i < 20) begin
            @(posedge clk);
            #1;
            i++;
            if (valid === 1'b1) begin
                lat = i; od = d; oq = q; oovf = ovf;
            end else if (busy === 1'b1) begin
                busy_hi++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (d !== 24'h0)    begin miscompares++; $display("[TB] FAIL reset_d: got %h expected %h", d, 24'h0); end
        vectors++; if (q !== 24'h0)    begin miscompares++; $display("[TB] FAIL reset_q: got %h expected %h", q, 24'h0); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (ovf !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_park0();
        logic [23:0] rd, rq; logic rovf; int lat, bh;
        run_conv(24'h001000, 24'h800800, 24'h800800, 24'h001000, 24'h000000, rd, rq, rovf, lat, bh);
        vectors++; if (lat !== 12)       begin miscompares++; $display("[TB] FAIL park0_latency: got %0d expected 12", lat); end
        vectors++; if (rd !== 24'h000FFF) begin miscompares++; $display("[TB] FAIL park0_d: got %h expected %h", rd, 24'h000FFF); end
        vectors++; if (rq !== 24'h000000) begin miscompares++; $display("[TB] FAIL park0_q: got %h expected %h", rq, 24'h000000); end
        vectors++; if (rovf !== 1'b0)     begin miscompares++; $display("[TB] FAIL park0_ovf: got %b expected 0", rovf); end
        vectors++; if (bh !== 12)         begin miscompares++; $display("[TB] FAIL park0_busy_cycles: got %0d expected 12", bh); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL park0_busy_at_valid: got %b expected 0", busy); end
    endtask

    task automatic test_park90();
        logic [23:0] rd, rq; logic rovf; int lat, bh;
        run_conv(24'h001000, 24'h800800, 24'h800800, 24'h000000, 24'h001000, rd, rq, rovf, lat, bh);
        vectors++; if (lat !== 12)       begin miscompares++; $display("[TB] FAIL park90_latency: got %0d expected 12", lat); end
        vectors++; if (rd !== 24'h000000) begin miscompares++; $display("[TB] FAIL park90_d: got %h expected %h", rd, 24'h000000); end
        vectors++; if (rq !== 24'h800FFF) begin miscompares++; $display("[TB] FAIL park90_q: got %h expected %h", rq, 24'h800FFF); end
        vectors++; if (rovf !== 1'b0)     begin miscompares++; $display("[TB] FAIL park90_ovf: got %b expected 0", rovf); end
    endtask

    task automatic test_beta_path();
        logic [23:0] rd, rq; logic rovf; int lat, bh;
        run_conv(24'h000000, 24'h000800, 24'h800800, 24'h001000, 24'h000000, rd, rq, rovf, lat, bh);
        vectors++; if (rd !== 24'h000000) begin miscompares++; $display("[TB] FAIL beta_d: got %h expected %h", rd, 24'h000000); end
        vectors++; if (rq !== 24'h00093D) begin miscompares++; $display("[TB] FAIL beta_q: got %h expected %h", rq, 24'h00093D); end
        vectors++; if (rovf !== 1'b0)     begin miscompares++; $display("[TB] FAIL beta_ovf: got %b expected 0", rovf); end
    endtask

    task automatic test_saturation();
        logic [23:0] rd, rq; logic rovf; int lat, bh;
        run_conv(24'h400000, 24'h000000, 24'h000000, 24'h001000, 24'h000000, rd, rq, rovf, lat, bh);
        vectors++; if (lat !== 12)       begin miscompares++; $display("[TB] FAIL sat_latency: got %0d expected 12", lat); end
        vectors++; if (rd !== 24'h2AA7FF) begin miscompares++; $display("[TB] FAIL sat_d: got %h expected %h", rd, 24'h2AA7FF); end
        vectors++; if (rq !== 24'h000000) begin miscompares++; $display("[TB] FAIL sat_q: got %h expected %h", rq, 24'h000000); end
        vectors++; if (rovf !== 1'b1)     begin miscompares++; $display("[TB] FAIL sat_ovf: got %b expected 1", rovf); end
        @(posedge clk);
        #1;
        vectors++; if (valid !== 1'b0)    begin miscompares++; $display("[TB] FAIL sat_valid_width: got %b expected 0", valid); end
        vectors++; if (ovf !== 1'b0)      begin miscompares++; $display("[TB] FAIL sat_ovf_width: got %b expected 0", ovf); end
        vectors++; if (d !== 24'h2AA7FF)  begin miscompares++; $display("[TB] FAIL sat_d_hold: got %h expected %h", d, 24'h2AA7FF); end
    endtask

    task automatic test_handshake();
        int nvalid, vcycle;
        nvalid = 0; vcycle = -1;
        @(negedge clk);
        A = 24'h001000; B = 24'h800800; C = 24'h800800; CosQ = 24'h001000; SinQ = 24'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 7);
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin nvalid++; vcycle = i; end
        end
        start = 1'b0;
        vectors++; if (nvalid !== 1)  begin miscompares++; $display("[TB] FAIL hs_valid_count: got %0d expected 1", nvalid); end
        vectors++; if (vcycle !== 12) begin miscompares++; $display("[TB] FAIL hs_valid_cycle: got %0d expected 12", vcycle); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] vmask, exp_mask;
        logic [23:0] d1, q1, d2, q2, d3, q3;
        int drops, dlat;
        vmask = '0; drops = 0; dlat = -1;
        d1 = 'x; q1 = 'x; d2 = 'x; q2 = 'x; d3 = 'x; q3 = 'x;
        exp_mask = (48'd1 << 12) | (48'd1 << 24) | (48'd1 << 36);
        @(negedge clk);
        A = 24'h001000; B = 24'h800800; C = 24'h800800; CosQ = 24'h001000; SinQ = 24'h0;
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 36; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) vmask[i] = 1'b1;
            if (busy !== 1'b1) drops++;
            if (i == 12) begin d1 = d; q1 = q; end
            if (i == 24) begin d2 = d; q2 = q; end
            if (i == 36) begin d3 = d; q3 = q; end
            if (i == 5) begin
                A = 24'h001000; B = 24'h800800; C = 24'h800800; CosQ = 24'h0; SinQ = 24'h001000;
            end
            if (i == 17) begin
                A = 24'h0; B = 24'h000800; C = 24'h800800; CosQ = 24'h001000; SinQ = 24'h0;
            end
        end
        start = 1'b0;
        for (int i = 1; i <= 20 && dlat < 0; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) dlat = i;
        end
        vectors++; if (vmask !== exp_mask) begin miscompares++; $display("[TB] FAIL b2b_valid_pattern: got %h expected %h", vmask, exp_mask); end
        vectors++; if (drops !== 0)        begin miscompares++; $display("[TB] FAIL b2b_busy_drops: got %0d expected 0", drops); end
        vectors++; if (d1 !== 24'h000FFF)  begin miscompares++; $display("[TB] FAIL b2b_d1: got %h expected %h", d1, 24'h000FFF); end
        vectors++; if (q1 !== 24'h000000)  begin miscompares++; $display("[TB] FAIL b2b_q1: got %h expected %h", q1, 24'h000000); end
        vectors++; if (d2 !== 24'h000000)  begin miscompares++; $display("[TB] FAIL b2b_d2: got %h expected %h", d2, 24'h000000); end
        vectors++; if (q2 !== 24'h800FFF)  begin miscompares++; $display("[TB] FAIL b2b_q2: got %h expected %h", q2, 24'h800FFF); end
        vectors++; if (d3 !== 24'h000000)  begin miscompares++; $display("[TB] FAIL b2b_d3: got %h expected %h", d3, 24'h000000); end
        vectors++; if (q3 !== 24'h00093D)  begin miscompares++; $display("[TB] FAIL b2b_q3: got %h expected %h", q3, 24'h00093D); end
        vectors++; if (dlat !== 12)        begin miscompares++; $display("[TB] FAIL b2b_drain_latency: got %0d expected 12", dlat); end
        vectors++; if (q !== 24'h00093D)   begin miscompares++; $display("[TB] FAIL b2b_drain_q: got %h expected %h", q, 24'h00093D); end
    endtask

    task automatic test_reset_midop();
        logic [23:0] rd, rq; logic rovf; int lat, bh, nv;
        nv = 0;
        @(negedge clk);
        A = 24'h001000; B = 24'h800800; C = 24'h800800; CosQ = 24'h0; SinQ = 24'h001000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 6; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (d !== 24'h0)    begin miscompares++; $display("[TB] FAIL midrst_d: got %h expected %h", d, 24'h0); end
        vectors++; if (q !== 24'h0)    begin miscompares++; $display("[TB] FAIL midrst_q: got %h expected %h", q, 24'h0); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid); end
        vectors++; if (ovf !== 1'b0)   begin miscompares++; $display("[TB] FAIL midrst_ovf: got %b expected 0", ovf); end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 9; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
        end
        vectors++; if (nv !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_valid: got %0d expected 0", nv); end
        run_conv(24'h000000, 24'h000800, 24'h800800, 24'h001000, 24'h000000, rd, rq, rovf, lat, bh);
        vectors++; if (lat !== 12)       begin miscompares++; $display("[TB] FAIL midrst_after_latency: got %0d expected 12", lat); end
        vectors++; if (rq !== 24'h00093D) begin miscompares++; $display("[TB] FAIL midrst_after_q: got %h expected %h", rq, 24'h00093D); end
        vectors++; if (rd !== 24'h000000) begin miscompares++; $display("[TB] FAIL midrst_after_d: got %h expected %h", rd, 24'h000000); end
    endtask

    // Bound on the whole run in case the DUT wedges somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_park0();
        test_park90();
        test_beta_path();
        test_saturation();
        test_handshake();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
